// File: rtl/exe_operand_stage.sv
// ID/EX pipeline register feeding the MIPS ALU: operand forwarding, a/b source
// selection, load-use hazard bubbles, and a saturating bubble counter.
module exe_operand_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_pc,
   input  logic [4:0]       id_rs_addr,
   input  logic [4:0]       id_rt_addr,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [31:0]      id_rs_data,
   input  logic [31:0]      id_rt_data,
   input  logic [31:0]      id_imm,
   input  logic [4:0]       id_shamt,
   input  logic [1:0]       id_a_sel,
   input  logic [1:0]       id_b_sel,
   input  logic [3:0]       id_oper,
   input  logic             id_sign,
   input  logic             id_wb_en,
   input  logic [4:0]       id_wb_addr,
   input  logic             id_mem_ren,
   input  logic [31:0]      alu_result,
   input  logic             mem_wb_en,
   input  logic [4:0]       mem_wb_addr,
   input  logic [31:0]      mem_data,
   input  logic             wb_wb_en,
   input  logic [4:0]       wb_wb_addr,
   input  logic [31:0]      wb_data,
   input  logic             stall_ext,
   input  logic             flush,
   output logic             exe_valid,
   output logic [31:0]      exe_a,
   output logic [31:0]      exe_b,
   output logic [3:0]       exe_oper,
   output logic             exe_sign,
   output logic [31:0]      exe_pc,
   output logic [31:0]      exe_rt_fwd,
   output logic             exe_wb_en,
   output logic [4:0]       exe_wb_addr,
   output logic             exe_mem_ren,
   output logic             id_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  oper;
      logic        sign;
      logic [31:0] pc;
      logic [31:0] rt_fwd;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic        mem_ren;
   } exe_t;

   typedef enum logic [1:0] {
      UPD_HOLD,
      UPD_BUBBLE,
      UPD_CAPTURE
   } upd_t;

   localparam logic [1:0] A_SHAMT = 2'd1;
   localparam logic [1:0] A_PC    = 2'd2;
   localparam logic [1:0] B_IMM   = 2'd1;
   localparam logic [1:0] B_FOUR  = 2'd2;

   exe_t             exe_q;
   exe_t             exe_d;
   upd_t             upd;
   logic [CNT_W-1:0] cnt_q;
   logic             ex_fwd_ok;
   logic             hazard;
   logic [31:0]      rs_fwd;
   logic [31:0]      rt_fwd;

   // A load still in EX has no data yet; it is covered by the hazard bubble.
   assign ex_fwd_ok = exe_q.valid & exe_q.wb_en & ~exe_q.mem_ren;

   function automatic logic [31:0] forward(
      input logic [4:0]  addr,
      input logic [31:0] rf_data,
      input logic        ex_ok,
      input logic [4:0]  ex_addr,
      input logic [31:0] ex_data,
      input logic        mem_en,
      input logic [4:0]  mem_addr,
      input logic [31:0] mem_val,
      input logic        wb_en,
      input logic [4:0]  wb_addr,
      input logic [31:0] wb_val
   );
      logic [31:0] result;
      result = rf_data;
      if (addr != 5'd0) begin
         if (ex_ok && addr == ex_addr)
            result = ex_data;
         else if (mem_en && addr == mem_addr)
            result = mem_val;
         else if (wb_en && addr == wb_addr)
            result = wb_val;
      end
      return result;
   endfunction

   assign rs_fwd = forward(id_rs_addr, id_rs_data, ex_fwd_ok, exe_q.wb_addr, alu_result,
                           mem_wb_en, mem_wb_addr, mem_data, wb_wb_en, wb_wb_addr, wb_data);
   assign rt_fwd = forward(id_rt_addr, id_rt_data, ex_fwd_ok, exe_q.wb_addr, alu_result,
                           mem_wb_en, mem_wb_addr, mem_data, wb_wb_en, wb_wb_addr, wb_data);

   assign hazard = id_valid & exe_q.valid & exe_q.mem_ren & exe_q.wb_en &
                   (exe_q.wb_addr != 5'd0) &
                   ((id_rs_used & (id_rs_addr == exe_q.wb_addr)) |
                    (id_rt_used & (id_rt_addr == exe_q.wb_addr)));

   assign id_stall = (hazard | stall_ext) & ~flush;

   always_comb begin
      // NOTE: every field gets a value before the case so no latch is inferred.
      exe_d         = '0;
      exe_d.valid   = 1'b1;
      exe_d.oper    = id_oper;
      exe_d.sign    = id_sign;
      exe_d.pc      = id_pc;
      exe_d.rt_fwd  = rt_fwd;
      exe_d.wb_en   = id_wb_en;
      exe_d.wb_addr = id_wb_addr;
      exe_d.mem_ren = id_mem_ren;

      case (id_a_sel)
         A_SHAMT: exe_d.a = {27'b0, id_shamt};
         A_PC:    exe_d.a = id_pc;
         default: exe_d.a = rs_fwd;
      endcase

      case (id_b_sel)
         B_IMM:   exe_d.b = id_imm;
         B_FOUR:  exe_d.b = 32'd4;
         default: exe_d.b = rt_fwd;
      endcase
   end

   // Priority order: flush, external stall, load-use hazard, capture, idle bubble.
   always_comb begin
      upd = UPD_BUBBLE;
      if (flush)
         upd = UPD_BUBBLE;
      else if (stall_ext)
         upd = UPD_HOLD;
      else if (hazard)
         upd = UPD_BUBBLE;
      else if (id_valid)
         upd = UPD_CAPTURE;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update from pre-edge values regardless of statement order.
      if (rst) begin
         exe_q <= '0;
         cnt_q <= '0;
      end else begin
         case (upd)
            UPD_CAPTURE: exe_q <= exe_d;
            UPD_BUBBLE: begin
               exe_q <= '0;
               if (cnt_q != '1)
                  cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: exe_q <= exe_q;
         endcase
      end
   end

   assign exe_valid   = exe_q.valid;
   assign exe_a       = exe_q.a;
   assign exe_b       = exe_q.b;
   assign exe_oper    = exe_q.oper;
   assign exe_sign    = exe_q.sign;
   assign exe_pc      = exe_q.pc;
   assign exe_rt_fwd  = exe_q.rt_fwd;
   assign exe_wb_en   = exe_q.wb_en;
   assign exe_wb_addr = exe_q.wb_addr;
   assign exe_mem_ren = exe_q.mem_ren;
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Scoreboard bench for exe_operand_stage: stimulus pushes expected EX state,
// a monitor pops and compares one cycle later.
module tb_exe_operand_stage;

   localparam int CNT_W = 16;
   localparam logic [3:0] OP_ADD = 4'd2;

   typedef struct packed {
      logic             valid;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [3:0]       oper;
      logic             sign;
      logic [31:0]      pc;
      logic [31:0]      rt_fwd;
      logic             wb_en;
      logic [4:0]       wb_addr;
      logic             mem_ren;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic id_valid;
   logic [31:0] id_pc;
   logic [4:0] id_rs_addr, id_rt_addr;
   logic id_rs_used, id_rt_used;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0] id_shamt;
   logic [1:0] id_a_sel, id_b_sel;
   logic [3:0] id_oper;
   logic id_sign, id_wb_en;
   logic [4:0] id_wb_addr;
   logic id_mem_ren;
   logic [31:0] alu_result;
   logic mem_wb_en;
   logic [4:0] mem_wb_addr;
   logic [31:0] mem_data;
   logic wb_wb_en;
   logic [4:0] wb_wb_addr;
   logic [31:0] wb_data;
   logic stall_ext, flush;
   logic exe_valid;
   logic [31:0] exe_a, exe_b;
   logic [3:0] exe_oper;
   logic exe_sign;
   logic [31:0] exe_pc, exe_rt_fwd;
   logic exe_wb_en;
   logic [4:0] exe_wb_addr;
   logic exe_mem_ren;
   logic id_stall;
   logic [CNT_W-1:0] bubble_cnt;

   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];
   string name_q[$];
   logic [CNT_W-1:0] exp_cnt;
   exp_t last;

   always #5 clk = ~clk;

   exe_operand_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .id_oper(id_oper), .id_sign(id_sign),
      .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
      .alu_result(alu_result),
      .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr), .mem_data(mem_data),
      .wb_wb_en(wb_wb_en), .wb_wb_addr(wb_wb_addr), .wb_data(wb_data),
      .stall_ext(stall_ext), .flush(flush),
      .exe_valid(exe_valid), .exe_a(exe_a), .exe_b(exe_b),
      .exe_oper(exe_oper), .exe_sign(exe_sign), .exe_pc(exe_pc),
      .exe_rt_fwd(exe_rt_fwd), .exe_wb_en(exe_wb_en),
      .exe_wb_addr(exe_wb_addr), .exe_mem_ren(exe_mem_ren),
      .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   function automatic exp_t cap(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] oper, input logic sign,
                                input logic [31:0] pc, input logic [31:0] rtf,
                                input logic wb_en, input logic [4:0] wb_addr,
                                input logic ren, input logic [CNT_W-1:0] cnt);
      exp_t e;
      e = '{valid: 1'b1, a: a, b: b, oper: oper, sign: sign, pc: pc, rt_fwd: rtf,
            wb_en: wb_en, wb_addr: wb_addr, mem_ren: ren, cnt: cnt};
      return e;
   endfunction

   function automatic exp_t bub(input logic [CNT_W-1:0] cnt);
      exp_t e;
      e = '0;
      e.cnt = cnt;
      return e;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   // Monitor: compares registered outputs #1 after each edge with the queued expectation.
   initial begin
      exp_t act;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            nm = name_q.pop_front();
            act = '{valid: exe_valid, a: exe_a, b: exe_b, oper: exe_oper, sign: exe_sign,
                    pc: exe_pc, rt_fwd: exe_rt_fwd, wb_en: exe_wb_en,
                    wb_addr: exe_wb_addr, mem_ren: exe_mem_ren, cnt: bubble_cnt};
            check(nm, 256'(act), 256'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clr();
      id_valid = 0; id_pc = 0; id_rs_addr = 0; id_rt_addr = 0;
      id_rs_used = 0; id_rt_used = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_shamt = 0; id_a_sel = 0; id_b_sel = 0; id_oper = 0;
      id_sign = 0; id_wb_en = 0; id_wb_addr = 0; id_mem_ren = 0;
      alu_result = 0; mem_wb_en = 0; mem_wb_addr = 0; mem_data = 0;
      wb_wb_en = 0; wb_wb_addr = 0; wb_data = 0; stall_ext = 0; flush = 0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [1:0] a_sel, input logic [1:0] b_sel,
                        input logic [31:0] imm, input logic wb_en,
                        input logic [4:0] wb_addr, input logic ren);
      id_valid = 1; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt;
      id_rs_used = 1; id_rt_used = 1; id_rs_data = rs_d; id_rt_data = rt_d;
      id_a_sel = a_sel; id_b_sel = b_sel; id_imm = imm; id_oper = OP_ADD;
      id_sign = 1; id_wb_en = wb_en; id_wb_addr = wb_addr; id_mem_ren = ren;
   endtask

   task automatic step(input string nm, input logic chk, input exp_t e);
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      last = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic stall_chk(input string nm, input logic req);
      #1;
      check(nm, 256'(id_stall), 256'(req));
   endtask

   initial begin
      clr();
      rst = 1;
      exp_cnt = 0;
      step("reset0", 1, bub(0));
      step("reset1", 1, bub(0));
      rst = 0;

      // Plain ADD r3,r1,r2 with no forwarding sources active.
      instr(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 2'd0, 2'd0, 0, 1, 5'd3, 0);
      stall_chk("add_stall", 0);
      step("add", 1, cap(5, 7, OP_ADD, 1, 32'h100, 7, 1, 3, 0, exp_cnt));

      // Producer of r1 enters EX.
      instr(32'h104, 5'd0, 5'd0, 32'h11, 32'h22, 2'd0, 2'd0, 0, 1, 5'd1, 0);
      step("prod_r1", 1, cap(32'h11, 32'h22, OP_ADD, 1, 32'h104, 32'h22, 1, 1, 0, exp_cnt));

      // Forwarding priority EX > MEM > WB > register file.
      clr();
      instr(32'h108, 5'd1, 5'd1, 32'h99, 32'h99, 2'd0, 2'd0, 0, 1, 5'd5, 0);
      alu_result = 32'h10;
      mem_wb_en = 1; mem_wb_addr = 5'd1; mem_data = 32'h20;
      wb_wb_en = 1; wb_wb_addr = 5'd1; wb_data = 32'h30;
      step("fwd_ex", 1, cap(32'h10, 32'h10, OP_ADD, 1, 32'h108, 32'h10, 1, 5, 0, exp_cnt));
      id_pc = 32'h10C; id_wb_addr = 5'd6;
      step("fwd_mem", 1, cap(32'h20, 32'h20, OP_ADD, 1, 32'h10C, 32'h20, 1, 6, 0, exp_cnt));
      mem_wb_en = 0; id_pc = 32'h110; id_wb_addr = 5'd7; id_b_sel = 2'd1; id_imm = 32'h55;
      step("fwd_wb", 1, cap(32'h30, 32'h55, OP_ADD, 1, 32'h110, 32'h30, 1, 7, 0, exp_cnt));
      wb_wb_en = 0; id_pc = 32'h114; id_b_sel = 2'd0;
      step("fwd_rf", 1, cap(32'h99, 32'h99, OP_ADD, 1, 32'h114, 32'h99, 1, 7, 0, exp_cnt));

      // Load-use: LW r4 then ADD r5,r4,r0.
      clr();
      instr(32'h118, 5'd0, 5'd0, 32'h1000, 32'h0, 2'd0, 2'd1, 32'd8, 1, 5'd4, 1);
      step("lw", 1, cap(32'h1000, 8, OP_ADD, 1, 32'h118, 0, 1, 4, 1, exp_cnt));
      instr(32'h120, 5'd4, 5'd0, 32'h1111, 32'h0, 2'd0, 2'd0, 0, 1, 5'd5, 0);
      stall_chk("lu_stall", 1);
      exp_cnt = sat_inc(exp_cnt);
      step("lu_bubble", 1, bub(exp_cnt));
      mem_wb_en = 1; mem_wb_addr = 5'd4; mem_data = 32'hDEAD;
      stall_chk("lu_release", 0);
      step("lu_fwd_mem", 1, cap(32'hDEAD, 0, OP_ADD, 1, 32'h120, 0, 1, 5, 0, exp_cnt));

      // r0 guard against both a load to r0 and an ALU write to r0.
      clr();
      instr(32'h124, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 1, 5'd0, 1);
      step("lw_r0", 1, cap(0, 0, OP_ADD, 1, 32'h124, 0, 1, 0, 1, exp_cnt));
      instr(32'h128, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 1, 5'd0, 0);
      alu_result = 32'hFFFF;
      stall_chk("r0_no_hazard", 0);
      step("r0_after_load", 1, cap(0, 0, OP_ADD, 1, 32'h128, 0, 1, 0, 0, exp_cnt));
      id_pc = 32'h12C; id_wb_en = 0;
      step("r0_after_alu", 1, cap(0, 0, OP_ADD, 1, 32'h12C, 0, 0, 0, 0, exp_cnt));

      // Operand source selects.
      clr();
      instr(32'h130, 5'd0, 5'd0, 32'h77, 32'h88, 2'd1, 2'd1, 32'hFFFF_FFF0, 0, 5'd0, 0);
      id_shamt = 5'd3;
      step("sel_shamt_imm", 1, cap(3, 32'hFFFF_FFF0, OP_ADD, 1, 32'h130, 32'h88, 0, 0, 0, exp_cnt));
      id_a_sel = 2'd2; id_b_sel = 2'd2; id_pc = 32'h400;
      step("sel_pc_four", 1, cap(32'h400, 4, OP_ADD, 1, 32'h400, 32'h88, 0, 0, 0, exp_cnt));
      id_a_sel = 2'd3; id_b_sel = 2'd3; id_pc = 32'h404; id_rs_data = 32'hA; id_rt_data = 32'hB;
      step("sel_3_3", 1, cap(32'hA, 32'hB, OP_ADD, 1, 32'h404, 32'hB, 0, 0, 0, exp_cnt));

      // stall_ext freezes outputs while WB forwarding data changes.
      clr();
      instr(32'h200, 5'd2, 5'd3, 32'h1, 32'h2, 2'd0, 2'd0, 0, 1, 5'd9, 0);
      wb_wb_en = 1; wb_wb_addr = 5'd2; wb_data = 32'h300;
      step("pre_stall", 1, cap(32'h300, 2, OP_ADD, 1, 32'h200, 2, 1, 9, 0, exp_cnt));
      stall_ext = 1;
      for (int i = 0; i < 3; i++) begin
         wb_data = 32'h400 + 32'(i) * 32'h100;
         id_pc = 32'h204;
         stall_chk("ext_stall", 1);
         step("stall_hold", 1, last);
      end
      stall_ext = 0;
      step("post_stall", 1, cap(32'h600, 2, OP_ADD, 1, 32'h204, 2, 1, 9, 0, exp_cnt));

      // Reset dominates an active stall.
      stall_ext = 1; rst = 1;
      exp_cnt = 0;
      step("rst_mid_stall", 1, bub(0));
      rst = 0;

      // flush beats hazard and stall_ext; id_stall drops.
      clr();
      instr(32'h300, 5'd0, 5'd0, 32'h2000, 0, 2'd0, 2'd1, 32'd4, 1, 5'd4, 1);
      step("lw2", 1, cap(32'h2000, 4, OP_ADD, 1, 32'h300, 0, 1, 4, 1, exp_cnt));
      instr(32'h304, 5'd4, 5'd0, 0, 0, 2'd0, 2'd0, 0, 1, 5'd5, 0);
      flush = 1;
      stall_chk("flush_hazard_stall", 0);
      exp_cnt = sat_inc(exp_cnt);
      step("flush_hazard", 1, bub(exp_cnt));
      stall_ext = 1;
      stall_chk("flush_ext_stall", 0);
      exp_cnt = sat_inc(exp_cnt);
      step("flush_ext", 1, bub(exp_cnt));

      // Idle bubbles up to and past saturation.
      clr();
      for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
         exp_cnt = sat_inc(exp_cnt);
         step("sat_bubble", (i < 2) || (exp_cnt >= 16'hFFFD), bub(exp_cnt));
      end
      stall_ext = 1;
      step("sat_hold", 1, bub(exp_cnt));
      stall_ext = 0; flush = 1;
      step("sat_flush", 1, bub(16'hFFFF));
      flush = 0;

      @(posedge clk);
      #2;
      check("queue_drained", 256'(exp_q.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/exe_operand_stage.md
Name: exe_operand_stage

Overview:
- ID/EX pipeline register that directly feeds the MIPS ALU.
- It resolves operand forwarding from the EX, MEM and WB stages and selects the ALU a/b sources: register, shamt, PC, immediate or constant 4.
- It registers a, b, oper and sign for the ALU, detects load-use hazards, inserts bubbles and stalls the front end.
- It keeps a saturating bubble counter for performance debug.

Parameters:
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs_addr, id_rt_addr  in  5 each  source register numbers
- id_rs_used, id_rt_used  in  1 each  instruction actually reads rs/rt
- id_rs_data, id_rt_data  in  32 each  register-file read data (write-first file)
- id_imm  in  32  immediate, already sign- or zero-extended
- id_shamt  in  5  shift amount field
- id_a_sel  in  2  0=rs, 1=zero-extended shamt, 2=pc, 3=rs
- id_b_sel  in  2  0=rt, 1=imm, 2=32'd4, 3=rt
- id_oper  in  4  ALU operation code
- id_sign  in  1  signed flag
- id_wb_en, id_wb_addr  in  1, 5  destination register
- id_mem_ren  in  1  load instruction
- alu_result  in  32  combinational ALU result for the instruction currently in EX
- mem_wb_en, mem_wb_addr, mem_data  in  1, 5, 32  MEM-stage writeback (final value, load data included)
- wb_wb_en, wb_wb_addr, wb_data  in  1, 5, 32  WB-stage writeback
- stall_ext  in  1  downstream stall
- flush  in  1  kill the instruction entering EX
- exe_valid  out  1
- exe_a, exe_b  out  32 each  ALU operands
- exe_oper  out  4
- exe_sign  out  1
- exe_pc  out  32
- exe_rt_fwd  out  32  forwarded rt, used as store data
- exe_wb_en, exe_wb_addr, exe_mem_ren  out  1, 5, 1
- id_stall  out  1  hold IF/ID
- bubble_cnt  out  CNT_W

Behaviour:
- Forwarding is combinational, evaluated separately for rs and rt. Priority is EX > MEM > WB > register file:
  - EX source: exe_valid & exe_wb_en & !exe_mem_ren & addr match, supplies alu_result.
  - MEM source: mem_wb_en & addr match, supplies mem_data.
  - WB source: wb_wb_en & addr match, supplies wb_data.
  - Address 0 never matches; r0 always reads id_*_data.
- Hazard (combinational):
  - hazard = id_valid & exe_valid & exe_mem_ren & exe_wb_en & exe_wb_addr!=0 & ((id_rs_used & id_rs_addr==exe_wb_addr) | (id_rt_used & id_rt_addr==exe_wb_addr)).
- id_stall = (hazard | stall_ext) & !flush.
- Register update on posedge clk, first matching rule wins:
  1. rst: all outputs 0, bubble_cnt=0.
  2. flush: insert bubble.
  3. stall_ext: hold every output register; bubble_cnt unchanged.
  4. hazard: insert bubble.
  5. id_valid: capture the instruction.
  6. Otherwise: insert bubble.
- Bubble means exe_valid=0, exe_wb_en=0, exe_mem_ren=0, and all data/control outputs zeroed (oper=0, sign=0).
- Capture loads:
  - exe_a = selected source per id_a_sel.
  - exe_b = selected source per id_b_sel.
  - exe_rt_fwd = forwarded rt.
  - All other fields copied from id_*.
- exe_a with shamt select = {27'b0, id_shamt}.
- bubble_cnt increments only when rule 2, 4 or 6 actually inserts a bubble. It saturates at all-ones.
- Latency: one cycle from ID to the exe_* outputs.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, the EX match is gone (bubble), and MEM forwarding supplies the load data.
- Operands are latched at capture. Forwarding sources changing while stall_ext holds must not alter exe_a, exe_b or exe_rt_fwd.
- flush asserted together with hazard or stall_ext: the bubble is inserted and id_stall=0.
- rst asserted mid-stall: rst dominates; exe_valid=0 on the next edge.

Test Plan:
- Reset, then ADD r3,r1,r2 with rs=5, rt=7, no matches -> next cycle exe_valid=1, exe_a=5, exe_b=7, exe_oper=ADD, bubble_cnt=0.
- Back-to-back dependency: EX writes r1 with alu_result=0x10, MEM writes r1 with 0x20, WB writes r1 with 0x30; ID reads r1 -> exe_a=0x10. Remove the EX match -> 0x20. Remove the MEM match -> 0x30.
- Load-use: EX holds LW r4 (mem_ren=1); ID is ADD r5,r4,r0 -> id_stall=1, exe_valid=0 next cycle, bubble_cnt=1. Next cycle mem_data=0xDEAD for r4 -> exe_a=0xDEAD, id_stall=0.
- r0 guard: EX writes r0 with alu_result=0xFFFF; ID reads r0 with rs_data=0 -> exe_a=0, no hazard, even if the EX instruction is a load to r0.
- Source select: a_sel=1 with shamt=3 and b_sel=1 with imm=0xFFFFFFF0 -> exe_a=3, exe_b=0xFFFFFFF0. a_sel=2 with pc=0x400 and b_sel=2 -> exe_a=0x400, exe_b=4.
- Control priority:
  - stall_ext held 3 cycles while wb_data changes -> exe_* frozen and id_stall=1.
  - flush with hazard -> bubble, id_stall=0.
  - Force 2^CNT_W+2 bubbles -> bubble_cnt stays at all-ones.
